z80_io_uart_tx: RTL

- Z80 I/O-mapped UART transmitter, the successor to the fixed 115200-baud byte UART on the host board.
- Adds a parametrised TX FIFO, a runtime-programmable 16-bit baud divisor, configurable data and stop bits, and a readable status register with a sticky overflow flag.
- Sits behind host I/O decode. The host supplies port-select `addr`, level strobes `wr` and `rd` derived from nIORQ/nRD/nWR, and the CPU data bus.

---
 rtl/z80_io_uart_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/z80_io_uart_tx.sv
// Z80 I/O-mapped UART transmitter: TX FIFO, runtime 16-bit baud divisor, status register.
// Define UART_PARITY_EN to insert a parity bit after the data bits (even/odd via parity_odd).
module z80_io_uart_tx #(
    parameter int          DATA_BITS   = 8,
    parameter int          FIFO_AW     = 4,
    parameter int          STOP_BITS   = 1,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tx,
    output logic       busy
);

    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE   = 1;
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state, state_next;

    // Host strobes are levels: a write acts once on the cycle wr rises (wr=1, wr_q=0);
    // reads are side-effect free and rdata is valid combinationally while rd=1.
    logic wr_q;
    logic wr_pulse;
    logic wr_fifo, wr_ctrl, wr_div_lo, wr_div_hi;

    assign wr_pulse  = wr & ~wr_q;
    assign wr_fifo   = wr_pulse && (addr == 2'd0);
    assign wr_ctrl   = wr_pulse && (addr == 2'd1);
    assign wr_div_lo = wr_pulse && (addr == 2'd2);
    assign wr_div_hi = wr_pulse && (addr == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) wr_q <= 1'b0;
        else       wr_q <= wr;
    end

    // FIFO
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW:0]     wptr, rptr;
    logic                 empty, full, push_ok, pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign push_ok = wr_fifo & ~full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[FIFO_AW-1:0]] <= wdata[DATA_BITS-1:0];
    end

    // Control / status registers; a dropped push beats a same-cycle clear.
    logic        overflow;
    logic [15:0] divisor;
    logic [15:0] div_eff;
    logic        parity_odd;

    always_ff @(posedge clk) begin
        if (reset)                       overflow <= 1'b0;
        else if (wr_fifo && full)        overflow <= 1'b1;
        else if (wr_ctrl && wdata[0])    overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor <= DEFAULT_DIV;
        end else begin
            if (wr_div_lo) divisor[7:0]  <= wdata;
            if (wr_div_hi) divisor[15:8] <= wdata;
        end
    end

    assign div_eff = (divisor < 16'd2) ? 16'd2 : divisor;

`ifdef UART_PARITY_EN
    logic par_odd_q;

    always_ff @(posedge clk) begin
        if (reset)        parity_odd <= 1'b0;
        else if (wr_ctrl) parity_odd <= wdata[7];
    end
`else
    assign parity_odd = 1'b0;
`endif

    // Shifter datapath; bit_div is latched per bit so divisor writes never shorten a bit.
    logic [15:0]          cnt;
    logic [15:0]          bit_div;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 bit_end;

    assign bit_end = (cnt == bit_div - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_next = S_START;
                    pop        = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == LAST_DATA) begin
`ifdef UART_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_end && bit_idx == LAST_STOP) begin
                    if (!empty) begin
                        state_next = S_START;
                        pop        = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_div <= 16'd2;
            bit_idx <= '0;
            data_q  <= '0;
        end else begin
            if (state == S_IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
                bit_div <= div_eff;
            end else if (bit_end) begin
                cnt     <= '0;
                bit_div <= div_eff;
                bit_idx <= (state_next == state) ? bit_idx + 3'd1 : 3'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (pop) data_q <= mem[rptr[FIFO_AW-1:0]];
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)    par_odd_q <= 1'b0;
        else if (pop) par_odd_q <= parity_odd;
    end
`endif

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = data_q[bit_idx];
`ifdef UART_PARITY_EN
            S_PARITY: tx = (^data_q) ^ par_odd_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != S_IDLE) | ~empty;

    always_comb begin
        rdata = 8'h00;
        if (rd) begin
            case (addr)
                2'd1:    rdata = {parity_odd, 3'b000, overflow, full, empty, busy};
                2'd2:    rdata = divisor[7:0];
                2'd3:    rdata = divisor[15:8];
                default: rdata = 8'h00;
            endcase
        end
    end

endmodule
